result_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_byte_tx.sv | 87 ++++++++
 rtl/result_uart_tx.sv | 83 ++++++++
 tb/tb_result_uart_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the result UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned FRAME_BYTES       = 5;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: START/DATA/STOP sequencing with a baud counter.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       txd,
  output logic       busy
);

  tx_state_e   state, state_next;
  logic [15:0] baud_cnt, baud_next;
  logic [2:0]  bit_idx, bit_next;
  logic [7:0]  data;
  logic        baud_tc;

  assign baud_tc = (baud_cnt == 16'(CLK_DIV - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    byte_ready = 1'b0;
    baud_next  = (state == IDLE || baud_tc) ? '0 : baud_cnt + 16'd1;
    unique case (state)
      IDLE: begin
        if (byte_valid) begin
          byte_ready = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_tc) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (baud_tc) begin
          bit_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        // Accepting the next byte at the end of the stop bit keeps bytes gapless.
        if (baud_tc) begin
          if (byte_valid) begin
            byte_ready = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = data[bit_idx];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data     <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      if (byte_ready) data <= byte_data;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Streams the CPU result word as a 5-byte UART frame whenever it changes or a send is forced.
module result_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        send_req,
  output logic        txd,
  output logic        busy,
  output logic [7:0]  ovr_cnt
);

  logic [31:0] last_seen, pend, shift_word;
  logic        pend_v;
  logic [2:0]  byte_idx;
  logic        chg, load_new, consume;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;

  assign chg = (result != last_seen) | send_req;

  // The sync byte of a new frame is requested both from idle and while the last byte is on the line.
  assign load_new   = !busy || (byte_idx == 3'(FRAME_BYTES - 1));
  assign byte_valid = load_new ? pend_v : 1'b1;
  assign consume    = byte_ready && load_new;

  always_comb begin
    byte_data = SYNC_BYTE;
    if (!load_new) begin
      case (byte_idx)
        3'd0:    byte_data = shift_word[7:0];
        3'd1:    byte_data = shift_word[15:8];
        3'd2:    byte_data = shift_word[23:16];
        default: byte_data = shift_word[31:24];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_seen  <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      shift_word <= '0;
      byte_idx   <= '0;
      ovr_cnt    <= '0;
    end else begin
      last_seen <= result;
      if (chg) begin
        pend   <= result;
        pend_v <= 1'b1;
      end else if (consume) begin
        pend_v <= 1'b0;
      end
      if (chg && pend_v && !consume && ovr_cnt != '1) ovr_cnt <= ovr_cnt + 8'd1;
      if (byte_ready) begin
        if (load_new) begin
          shift_word <= pend;
          byte_idx   <= '0;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .txd       (txd),
    .busy      (busy)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: expected frames are queued by stimulus, a UART decoder pops and checks.
module tb_result_uart_tx;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = '0;
  logic        send_req = 1'b0;
  logic        txd, busy;
  logic [7:0]  ovr_cnt;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  bit ignore_bytes = 1'b0;
  bit mon_act = 1'b0;
  int busy_run = 0, last_run = 0, busy_total = 0;

  result_uart_tx #(
    .CLK_DIV  (DIV),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .result  (result),
    .send_req(send_req),
    .txd     (txd),
    .busy    (busy),
    .ovr_cnt (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || mon_act) && n < 3000);
    if (busy || mon_act) begin
      compared++;
      mismatched++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
    @(negedge clk);
  endtask

  // UART decoder: bit k centre sits at DIV*k + DIV/2 cycles after the start edge.
  initial begin
    int off, k;
    logic [7:0] sh;
    logic [7:0] e;
    off = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (txd == 1'b0) begin
          mon_act = 1'b1;
          off = 0;
        end
      end else begin
        off++;
        if (off % DIV == DIV / 2) begin
          k = off / DIV;
          if (k >= 1 && k <= 8) sh[k-1] = txd;
          else if (k == 9) begin
            mon_act = 1'b0;
            if (!ignore_bytes) begin
              if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL byte: got unexpected byte %02h, expected no byte", sh);
              end else begin
                e = exp_q.pop_front();
                check("byte", 32'(sh), 32'(e));
                check("stop_bit", 32'(txd), 32'd1);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_run++;
        busy_total++;
      end else if (busy_run > 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(ovr_cnt), 32'd0);
    repeat (300) @(negedge clk);
    check("no_frame_busy_cycles", 32'(busy_total), 32'd0);

    // 2: single change, txd falls two cycles later
    result = 32'h12345678;
    push_frame(32'h12345678);
    @(negedge clk);
    check("s2_txd_n1", 32'(txd), 32'd1);
    check("s2_busy_n1", 32'(busy), 32'd0);
    @(negedge clk);
    check("s2_txd_n2", 32'(txd), 32'd0);
    check("s2_busy_n2", 32'(busy), 32'd1);
    wait_idle("s2_idle");
    check("s2_busy_len", 32'(last_run), 32'd200);

    // 3: forced resend of an unchanged value
    repeat (10) @(negedge clk);
    send_req = 1'b1;
    push_frame(32'h12345678);
    @(negedge clk);
    send_req = 1'b0;
    check("s3_txd_n1", 32'(txd), 32'd1);
    @(negedge clk);
    check("s3_txd_n2", 32'(txd), 32'd0);
    wait_idle("s3_idle");
    check("s3_busy_len", 32'(last_run), 32'd200);
    check("s3_ovr", 32'(ovr_cnt), 32'd0);

    // 4: overwrites during a frame, newest value follows back-to-back
    result = 32'hCAFEF00D;
    push_frame(32'hCAFEF00D);
    repeat (20) @(negedge clk);
    result = 32'd1;
    @(negedge clk);
    result = 32'd2;
    @(negedge clk);
    result = 32'd3;
    push_frame(32'd3);
    wait_idle("s4_idle");
    check("s4_busy_len", 32'(last_run), 32'd400);
    check("s4_ovr", 32'(ovr_cnt), 32'd2);

    // 5: saturation, then reset in the middle of frame byte 2
    ignore_bytes = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      result = result ^ 32'h1;
    end
    @(negedge clk);
    check("s5_ovr_sat", 32'(ovr_cnt), 32'd255);
    wait_idle("s5_idle");
    result = 32'h0BADBEEF;
    @(negedge clk);
    @(negedge clk);
    check("s5_txd_fall", 32'(txd), 32'd0);
    repeat (2 * 10 * DIV + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("s5_rst_txd", 32'(txd), 32'd1);
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_ovr", 32'(ovr_cnt), 32'd0);
    @(negedge clk);
    exp_q.delete();
    ignore_bytes = 1'b0;
    push_frame(32'h0BADBEEF);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_idle("post_rst_idle");
    check("post_rst_busy_len", 32'(last_run), 32'd200);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
